// File: rtl/mips_dmem_responder.sv
// MIPS data-memory responder: word RAM behind a req/ready port
// with programmable wait states and error reporting.
module mips_dmem_responder #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);
  localparam logic [3:0]  WLOAD =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic        cap;
  logic        go;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_be;
  logic [31:0] c_off;
  logic        c_bad;
  logic [AW-1:0] c_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    go      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cap = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go      = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WLOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          go      = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access happens on the capture edge,
  // so the live inputs are used instead of the captured copies.
  always_comb begin
    c_we    = cap ? we    : we_q;
    c_addr  = cap ? addr  : addr_q;
    c_wdata = cap ? wdata : wdata_q;
    c_be    = cap ? be    : be_q;
    c_off   = c_addr - BASE_ADDR;
    c_bad   = (c_addr < BASE_ADDR) || (c_off >= SPAN) ||
              (c_addr[1:0] != 2'b00);
    c_idx   = c_off[AW+1:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
      end
      if (go) begin
        err_q   <= c_bad;
        rdata_q <= (c_bad || c_we) ? 32'd0 : mem[c_idx];
      end else begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // Contents survive reset; rst only blocks a write on its edge.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      if (go && c_we && !c_bad) begin
        for (int i = 0; i < 4; i++) begin
          if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

  assign ready = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule
